// File: rtl/block_accumulator_pkg.sv
// Shared definitions for the block accumulator: FSM encoding and default sizes.
package block_accumulator_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/block_accumulator_rca.sv
// Ripple-carry adder: a + b + cin as a chain of full-adder cells.
module block_accumulator_rca #(
    parameter int WIDTH = block_accumulator_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/block_accumulator.sv
// Streaming multi-operand accumulator: sums a block of beats and presents
// sum, sticky carry and saturating beat count on a valid/ready output.
module block_accumulator
    import block_accumulator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [WIDTH-1:0] rca_sum;
    logic             rca_cout;
    logic             accept;
    logic             deliver;

    block_accumulator_rca #(.WIDTH(WIDTH)) u_rca (
        .a    (acc_reg),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // In HOLD a new beat is only taken when the held result leaves the same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: in_ready = 1'b1;
                ST_ACC:  in_ready = 1'b1;
                ST_HOLD: in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign out_valid = (state_reg == ST_HOLD);
    assign out_sum   = acc_reg;
    assign out_carry = carry_reg;
    assign out_count = count_reg;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        carry_next = carry_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    acc_next   = in_data;
                    carry_next = 1'b0;
                    count_next = CNT_ONE;
                    state_next = in_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    acc_next   = rca_sum;
                    carry_next = carry_reg | rca_cout;
                    count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_ONE;
                    state_next = in_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (deliver) begin
                    if (accept) begin
                        acc_next   = in_data;
                        carry_next = 1'b0;
                        count_next = CNT_ONE;
                        state_next = in_last ? ST_HOLD : ST_ACC;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_block_accumulator.sv
// Self-checking bench: directed scenarios then random traffic, compared with a
// block-level reference model on a CNT_W=8 and a CNT_W=2 instance.
module tb_block_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_carry;
    logic [31:0] out_sum;
    logic [7:0]  out_count;

    logic        in_ready_s, out_valid_s, out_carry_s;
    logic [31:0] out_sum_s;
    logic [1:0]  out_count_s;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: beats of the open block and the held result.
    logic [31:0] blk[$];
    bit          hold = 1'b0;
    logic [31:0] e_sum;
    bit          e_carry;
    int          e_n;

    always #5 clk = ~clk;

    block_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
        .out_count(out_count)
    );

    block_accumulator #(.WIDTH(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sum(out_sum_s), .out_carry(out_carry_s),
        .out_count(out_count_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sum modulo 2**32, carry set if any pairwise addition overflowed.
    task automatic close_block();
        logic [32:0] t;
        e_sum   = blk[0];
        e_carry = 1'b0;
        e_n     = blk.size();
        for (int i = 1; i < blk.size(); i++) begin
            t = {1'b0, e_sum} + {1'b0, blk[i]};
            e_sum = t[31:0];
            if (t[32]) e_carry = 1'b1;
        end
        blk.delete();
        hold = 1'b1;
    endtask

    // One clock cycle: drive, check at negedge, advance the model, cross posedge.
    task automatic step(input bit r, input bit v, input logic [31:0] d, input bit l, input bit ordy);
        bit exp_ready;
        bit acc_b;
        rst = r; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        @(negedge clk);
        exp_ready = !r && (!hold || ordy);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        chk("in_ready_s", {63'd0, in_ready_s}, {63'd0, exp_ready});
        chk("out_valid", {63'd0, out_valid}, {63'd0, hold});
        chk("out_valid_s", {63'd0, out_valid_s}, {63'd0, hold});
        if (hold) begin
            chk("out_sum", {32'd0, out_sum}, {32'd0, e_sum});
            chk("out_carry", {63'd0, out_carry}, {63'd0, e_carry});
            chk("out_count", {56'd0, out_count}, 64'(e_n > 255 ? 255 : e_n));
            chk("out_count_sat", {62'd0, out_count_s}, 64'(e_n > 3 ? 3 : e_n));
        end
        acc_b = v && exp_ready;
        if (r) begin
            blk.delete();
            hold = 1'b0;
        end else begin
            if (hold && ordy) hold = 1'b0;
            if (acc_b) begin
                blk.push_back(d);
                if (l) close_block();
            end
        end
        $display("cyc rst=%0b v=%0b d=%08h last=%0b ordy=%0b | rdy=%0b ov=%0b sum=%08h c=%0b n=%0d",
                 r, v, d, l, ordy, in_ready, out_valid, out_sum, out_carry, out_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_carry", {63'd0, out_carry}, 64'd0);
        chk("rst_count", {56'd0, out_count}, 64'd0);

        // Three-beat block 5,7,9
        step(0, 1, 32'd5, 0, 1);
        step(0, 1, 32'd7, 0, 1);
        step(0, 1, 32'd9, 1, 1);
        step(0, 0, 32'd0, 0, 1);
        step(0, 0, 32'd0, 0, 1);

        // Carry-producing block
        step(0, 1, 32'hFFFF_FFFF, 0, 1);
        step(0, 1, 32'h0000_0002, 0, 1);
        step(0, 1, 32'h0000_0001, 1, 1);
        step(0, 0, 32'd0, 0, 1);

        // Single beat held under backpressure
        step(0, 1, 32'd42, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'd99, 0, 0);
        step(0, 0, 32'd0, 0, 1);
        step(0, 0, 32'd0, 0, 1);

        // Deliver and accept in the same cycle
        step(0, 1, 32'd1, 0, 1);
        step(0, 1, 32'd2, 1, 1);
        step(0, 1, 32'd10, 0, 1);
        step(0, 1, 32'd5, 1, 1);
        step(0, 0, 32'd0, 0, 1);

        // Reset mid-block
        step(0, 1, 32'd1, 0, 1);
        step(0, 1, 32'd2, 0, 1);
        step(1, 1, 32'd3, 0, 1);
        step(0, 0, 32'd0, 0, 1);
        step(0, 1, 32'd3, 0, 1);
        step(0, 1, 32'd4, 1, 1);
        step(0, 0, 32'd0, 0, 1);

        // Six ones: saturates the narrow counter
        for (int i = 0; i < 6; i++) step(0, 1, 32'd1, (i == 5), 1);
        step(0, 0, 32'd0, 0, 1);

        // Random traffic, including occasional reset and large operands
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), d,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
